// File: rtl/bfs_queue_drain_pkg.sv
// Shared BFS types for the frontier-queue read side: node/row widths and the
// drain serialiser state encoding.
package bfs_queue_drain_pkg;

  localparam int unsigned NODE_W = 32;
  localparam int unsigned ROW_W  = 64;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD1 = 2'd1,
    HOLD2 = 2'd2
  } drain_state_e;

  // Select entry0 (hi=0) or entry1 (hi=1) of a queue row.
  function automatic logic [NODE_W-1:0] row_entry(input logic [ROW_W-1:0] row,
                                                  input logic             hi);
    return hi ? row[ROW_W-1:NODE_W] : row[NODE_W-1:0];
  endfunction

endpackage

// File: rtl/bfs_queue_drain.sv
// Frontier-queue drain: pops 64-bit rows, serialises them into 32-bit node IDs
// on a valid/ready stream, holds back half rows the producer may still complete.
module bfs_queue_drain
  import bfs_queue_drain_pkg::*;
#(
  parameter int unsigned HALF_WAIT = 4,
  parameter int unsigned CNT_W     = 32
) (
  input  logic              clk,
  input  logic              bfs_rstn,
  input  logic              drain_en,
  input  logic              flush,
  input  logic              enq_active,
  input  logic              queue_empty,
  input  logic              rdata_filled,
  input  logic [ROW_W-1:0]  rdata_out,
  output logic              dequeue_req,
  output logic              node_valid,
  output logic [NODE_W-1:0] node_id,
  input  logic              node_ready,
  output logic [CNT_W-1:0]  issued_count,
  output logic              idle
);

  localparam int unsigned HC_W = $clog2(HALF_WAIT + 2);

  drain_state_e      state, state_nxt;
  logic [HC_W-1:0]   half_cnt;
  logic [NODE_W-1:0] spare;
  logic              leaving;
  logic              half_row;
  logic              half_ripe;

  always_ff @(posedge clk or negedge bfs_rstn) begin
    if (!bfs_rstn) state <= EMPTY;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    node_valid = (state != EMPTY);
    leaving    = (state == EMPTY) | ((state == HOLD1) & node_ready);
    half_row   = ~queue_empty & ~rdata_filled;
    half_ripe  = (half_cnt >= HC_W'(HALF_WAIT)) | flush;
    // Gated by reset so the combinational pop stays low while the block is held.
    dequeue_req = bfs_rstn & drain_en & ~queue_empty & leaving &
                  (rdata_filled | (half_ripe & ~enq_active));
    idle = (state == EMPTY) & queue_empty & ~dequeue_req;

    if (dequeue_req) begin
      state_nxt = rdata_filled ? HOLD2 : HOLD1;
    end else begin
      case (state)
        HOLD2:   if (node_ready) state_nxt = HOLD1;
        HOLD1:   if (node_ready) state_nxt = EMPTY;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge bfs_rstn) begin
    if (!bfs_rstn) begin
      node_id <= '0;
      spare   <= '0;
    end else if (dequeue_req) begin
      node_id <= row_entry(rdata_out, 1'b0);
      if (rdata_filled) spare <= row_entry(rdata_out, 1'b1);
    end else if ((state == HOLD2) && node_ready) begin
      node_id <= spare;
    end
  end

  // Counts quiet cycles of a half-filled head; any producer activity restarts it.
  always_ff @(posedge clk or negedge bfs_rstn) begin
    if (!bfs_rstn) begin
      half_cnt <= '0;
    end else if (dequeue_req | queue_empty | rdata_filled | enq_active) begin
      half_cnt <= '0;
    end else if (half_row && (half_cnt < HC_W'(HALF_WAIT))) begin
      half_cnt <= half_cnt + HC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge bfs_rstn) begin
    if (!bfs_rstn)                 issued_count <= '0;
    else if (node_valid & node_ready) issued_count <= issued_count + CNT_W'(1);
  end

endmodule
